stage_bus_fifo: RTL and testbench

STAGE_BUS_FIFO -- requirements
Module: stage_bus_fifo

---
 rtl/stage_bus_fifo.sv | 152 +++++++++++++++
 tb/tb_stage_bus_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stage_bus_fifo.sv
// rtl/stage_bus_fifo.sv - single-clock packet FIFO with status FSM and sticky error flags
//
// Purpose: DEPTH-entry circular buffer of DATA_WIDTH-bit packets between a
// producer (send/send_data) and a consumer (recv/recv_data). Status outputs
// come from registered state only, so there is no combinational path from
// send/recv to can_send/can_receive.
//
// Ports:
//   clk           in   1           clock, rising edge
//   rst_n         in   1           asynchronous active-low reset
//   flush         in   1           synchronous discard of all held packets
//   send          in   1           push send_data this cycle
//   send_data     in   DATA_WIDTH  packet to push
//   can_send      out  1           at least one entry free
//   can_receive   out  1           at least one packet held
//   recv          in   1           pop the head packet this cycle
//   recv_data     out  DATA_WIDTH  head packet (valid while can_receive=1)
//   count         out  CW          number of packets held
//   overflow_err  out  1           sticky: send while full
//   underflow_err out  1           sticky: recv while empty

module stage_bus_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         send,
  input  logic [DATA_WIDTH-1:0]        send_data,
  output logic                         can_send,
  output logic                         can_receive,
  input  logic                         recv,
  output logic [DATA_WIDTH-1:0]        recv_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_udf;
  state_t                r_state;
  state_t                w_state_nxt;

  logic w_can_send;
  logic w_can_recv;
  logic w_push;
  logic w_pop;

  assign w_can_send = (r_count != C_DEPTH);
  assign w_can_recv = (r_count != '0);

  // Flush wins over both strobes; a flushed strobe is neither accepted nor an error.
  assign w_push = send & w_can_send & ~flush;
  assign w_pop  = recv & w_can_recv & ~flush;

  assign can_send      = w_can_send;
  assign can_receive   = w_can_recv;
  assign recv_data     = r_mem[r_rptr];
  assign count         = r_count;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;

  // Datapath: storage, pointers, occupancy. Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= send_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (send & ~w_can_send & ~flush) begin
        r_ovf <= 1'b1;
      end
      if (recv & ~w_can_recv & ~flush) begin
        r_udf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_push && !w_pop) begin
      case (r_state)
        ST_EMPTY:   w_state_nxt = (C_DEPTH == C_ONE) ? ST_FULL : ST_PARTIAL;
        ST_PARTIAL: w_state_nxt = (r_count == C_LAST) ? ST_FULL : ST_PARTIAL;
        default:    w_state_nxt = r_state;
      endcase
    end else if (w_pop && !w_push) begin
      case (r_state)
        ST_FULL:    w_state_nxt = (C_DEPTH == C_ONE) ? ST_EMPTY : ST_PARTIAL;
        ST_PARTIAL: w_state_nxt = (r_count == C_ONE) ? ST_EMPTY : ST_PARTIAL;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_bus_fifo.sv
// tb/tb_stage_bus_fifo.sv - self-checking bench for stage_bus_fifo (DEPTH=4, DATA_WIDTH=64)

module tb_stage_bus_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        send;
  logic [63:0] send_data;
  logic        can_send;
  logic        can_receive;
  logic        recv;
  logic [63:0] recv_data;
  logic [2:0]  count;
  logic        overflow_err;
  logic        underflow_err;

  int total;
  int bad;

  stage_bus_fifo #(.DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .send         (send),
    .send_data    (send_data),
    .can_send     (can_send),
    .can_receive  (can_receive),
    .recv         (recv),
    .recv_data    (recv_data),
    .count        (count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        snd;
    logic        rcv;
    logic        fl;
    logic [63:0] d;
    logic        e_cs;
    logic        e_cr;
    logic [2:0]  e_cnt;
    logic        chk_d;
    logic [63:0] e_d;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic snd, logic rcv, logic fl, logic [63:0] d,
                              logic e_cs, logic e_cr, logic [2:0] e_cnt,
                              logic chk_d, logic [63:0] e_d, logic e_ovf, logic e_udf);
    vec_t v;
    v.snd = snd; v.rcv = rcv; v.fl = fl; v.d = d;
    v.e_cs = e_cs; v.e_cr = e_cr; v.e_cnt = e_cnt;
    v.chk_d = chk_d; v.e_d = e_d; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then return 1 time unit after it.
  task automatic apply(input logic snd, input logic rcv, input logic fl, input logic [63:0] d);
    send      = snd;
    recv      = rcv;
    flush     = fl;
    send_data = d;
    @(posedge clk);
    #1;
    send      = 1'b0;
    recv      = 1'b0;
    flush     = 1'b0;
    send_data = '0;
  endtask

  task automatic chk_status(input string tag, input logic cs, input logic cr, input logic [2:0] cnt,
                            input logic ovf, input logic udf);
    chk({tag, "_can_send"},    {63'd0, can_send},      {63'd0, cs});
    chk({tag, "_can_receive"}, {63'd0, can_receive},   {63'd0, cr});
    chk({tag, "_count"},       {61'd0, count},         {61'd0, cnt});
    chk({tag, "_overflow"},    {63'd0, overflow_err},  {63'd0, ovf});
    chk({tag, "_underflow"},   {63'd0, underflow_err}, {63'd0, udf});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    send      = 1'b0;
    recv      = 1'b0;
    send_data = '0;

    // Single transfer, fill past full, push+pop at full, drain.
    vecs[0]  = mk(1, 0, 0, 64'hA5, 1, 1, 3'd1, 1, 64'hA5, 0, 0);
    vecs[1]  = mk(0, 1, 0, 64'h0,  1, 0, 3'd0, 0, 64'h0,  0, 0);
    vecs[2]  = mk(1, 0, 0, 64'd1,  1, 1, 3'd1, 1, 64'd1,  0, 0);
    vecs[3]  = mk(1, 0, 0, 64'd2,  1, 1, 3'd2, 1, 64'd1,  0, 0);
    vecs[4]  = mk(1, 0, 0, 64'd3,  1, 1, 3'd3, 1, 64'd1,  0, 0);
    vecs[5]  = mk(1, 0, 0, 64'd4,  0, 1, 3'd4, 1, 64'd1,  0, 0);
    vecs[6]  = mk(1, 0, 0, 64'd5,  0, 1, 3'd4, 1, 64'd1,  1, 0);
    vecs[7]  = mk(1, 1, 0, 64'd6,  1, 1, 3'd3, 1, 64'd2,  1, 0);
    vecs[8]  = mk(0, 1, 0, 64'd0,  1, 1, 3'd2, 1, 64'd3,  1, 0);
    vecs[9]  = mk(0, 1, 0, 64'd0,  1, 1, 3'd1, 1, 64'd4,  1, 0);
    vecs[10] = mk(0, 1, 0, 64'd0,  1, 0, 3'd0, 0, 64'd0,  1, 0);
    vecs[11] = mk(0, 0, 0, 64'd0,  1, 0, 3'd0, 0, 64'd0,  1, 0);

    #12;
    chk_status("reset", 1, 0, 3'd0, 0, 0);
    chk("reset_recv_data", recv_data, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].snd, vecs[i].rcv, vecs[i].fl, vecs[i].d);
      chk_status($sformatf("vec%0d", i), vecs[i].e_cs, vecs[i].e_cr, vecs[i].e_cnt,
                 vecs[i].e_ovf, vecs[i].e_udf);
      if (vecs[i].chk_d) begin
        chk($sformatf("vec%0d_recv_data", i), recv_data, vecs[i].e_d);
      end
    end

    // Wrap: keep two packets in flight while streaming 0..9 through.
    apply(1, 0, 0, 64'd0);
    apply(1, 0, 0, 64'd1);
    for (int i = 2; i < 10; i++) begin
      chk($sformatf("wrap_data%0d", i - 2), recv_data, 64'(i - 2));
      apply(1, 1, 0, 64'(i));
      chk($sformatf("wrap_count%0d", i), {61'd0, count}, 64'd2);
    end
    chk("wrap_data8", recv_data, 64'd8);
    apply(0, 1, 0, 64'd0);
    chk("wrap_data9", recv_data, 64'd9);
    apply(0, 1, 0, 64'd0);
    chk_status("wrap_end", 1, 0, 3'd0, 1, 0);

    // Reset to clear the sticky flags, released between clock edges.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_status("rst2", 1, 0, 3'd0, 0, 0);

    // Flush at count=3 with a concurrent send and recv.
    apply(1, 0, 0, 64'd11);
    apply(1, 0, 0, 64'd12);
    apply(1, 0, 0, 64'd13);
    chk("pre_flush_count", {61'd0, count}, 64'd3);
    apply(1, 1, 1, 64'd99);
    chk_status("flush", 1, 0, 3'd0, 0, 0);
    apply(0, 1, 1, 64'd0);
    chk_status("flush_empty_recv", 1, 0, 3'd0, 0, 0);
    apply(1, 0, 0, 64'd21);
    chk("post_flush_data", recv_data, 64'd21);
    apply(1, 0, 0, 64'd22);
    chk("pre_arst_count", {61'd0, count}, 64'd2);

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk_status("arst", 1, 0, 3'd0, 0, 0);
    chk("arst_recv_data", recv_data, 64'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_status("arst_release", 1, 0, 3'd0, 0, 0);

    // Underflow on empty, then normal traffic, then flush keeps the flag.
    apply(0, 1, 0, 64'd0);
    chk_status("underflow", 1, 0, 3'd0, 0, 1);
    apply(1, 0, 0, 64'h7);
    chk_status("uf_push", 1, 1, 3'd1, 0, 1);
    chk("uf_push_data", recv_data, 64'h7);
    apply(0, 1, 0, 64'd0);
    chk_status("uf_pop", 1, 0, 3'd0, 0, 1);
    apply(0, 0, 1, 64'd0);
    chk_status("sticky_flush", 1, 0, 3'd0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
